ctrl_noc_pkt_rr_arb: RTL and testbench

CTRL_NOC_PKT_RR_ARB -- requirements
Module: ctrl_noc_pkt_rr_arb

---
 rtl/beehive_ctrl_noc_msg.sv | 20 ++
 rtl/ctrl_noc_rr_pick.sv | 43 ++++
 rtl/ctrl_noc_pkt_rr_arb.sv | 114 +++++++++++
 tb/tb_ctrl_noc_pkt_rr_arb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beehive_ctrl_noc_msg.sv
// rtl/beehive_ctrl_noc_msg.sv - shared ctrl-NoC message constants and flit-count helpers
//
// Purpose: constants and helper functions shared by the ctrl-NoC arbiter and the
// ctrl-to-data header converter, so both derive packet lengths identically.
// Ports: none (package).
package beehive_ctrl_noc_msg;

    localparam int CTRL_NOC1_DATA_W = 64;

    // Number of flits needed to carry extra_w extra-header bits.
    function automatic int ctrl_noc_extra_flits(input int extra_w);
        return (extra_w + CTRL_NOC1_DATA_W - 1) / CTRL_NOC1_DATA_W;
    endfunction

    // Width of a source index; never below 1 bit.
    function automatic int ctrl_noc_idx_w(input int num_srcs);
        return (num_srcs > 1) ? $clog2(num_srcs) : 1;
    endfunction

endpackage

// File: rtl/ctrl_noc_rr_pick.sv
// rtl/ctrl_noc_rr_pick.sv - combinational round-robin picker
//
// Purpose: returns the first asserted request at or after rr_ptr_i, wrapping
// modulo NUM_SRCS.
// Ports:
//   req_i       - request vector, one bit per source
//   rr_ptr_i    - search start index (must be < NUM_SRCS)
//   grant_idx_o - index of the selected source (0 when none)
//   any_req_o   - high when at least one request is asserted
module ctrl_noc_rr_pick
    import beehive_ctrl_noc_msg::*;
#(
    parameter int NUM_SRCS = 4
) (
    input  logic [NUM_SRCS-1:0]                        req_i,
    input  logic [ctrl_noc_idx_w(NUM_SRCS)-1:0]        rr_ptr_i,
    output logic [ctrl_noc_idx_w(NUM_SRCS)-1:0]        grant_idx_o,
    output logic                                       any_req_o
);

    localparam int IDX_W = ctrl_noc_idx_w(NUM_SRCS);

    int               sum;
    logic [IDX_W-1:0] idx;

    // Scan offsets from highest to lowest so the smallest offset from the
    // pointer is the last (and winning) assignment.
    always_comb begin
        grant_idx_o = '0;
        any_req_o   = 1'b0;
        sum         = 0;
        idx         = '0;
        for (int k = NUM_SRCS - 1; k >= 0; k--) begin
            sum = int'(rr_ptr_i) + k;
            idx = IDX_W'((sum >= NUM_SRCS) ? (sum - NUM_SRCS) : sum);
            if (req_i[idx]) begin
                grant_idx_o = idx;
                any_req_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctrl_noc_pkt_rr_arb.sv
// rtl/ctrl_noc_pkt_rr_arb.sv - packet-locked round-robin arbiter for ctrl-NoC flits
//
// Purpose: merges NUM_SRCS ctrl-NoC flit streams into one, granting a whole
// packet (2 header flits + extra flits) to one source at a time.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   src_arb_val    - per-source flit valid
//   src_arb_data   - per-source flit data
//   arb_src_rdy    - per-source ready (only the locked source can see ready)
//   arb_dst_val    - merged flit valid
//   arb_dst_data   - merged flit data
//   dst_arb_rdy    - downstream ready
//   arb_grant_idx  - locked source index (meaningful while arb_busy)
//   arb_busy       - high while a packet is locked
module ctrl_noc_pkt_rr_arb
    import beehive_ctrl_noc_msg::*;
#(
    parameter int NUM_SRCS = 4,
    parameter int EXTRA_W  = 64
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_SRCS-1:0]                         src_arb_val,
    input  logic [NUM_SRCS-1:0][CTRL_NOC1_DATA_W-1:0]   src_arb_data,
    output logic [NUM_SRCS-1:0]                         arb_src_rdy,
    output logic                                        arb_dst_val,
    output logic [CTRL_NOC1_DATA_W-1:0]                 arb_dst_data,
    input  logic                                        dst_arb_rdy,
    output logic [ctrl_noc_idx_w(NUM_SRCS)-1:0]         arb_grant_idx,
    output logic                                        arb_busy
);

    localparam int               IDX_W     = ctrl_noc_idx_w(NUM_SRCS);
    localparam int               PKT_FLITS = 2 + ctrl_noc_extra_flits(EXTRA_W);
    localparam int               CNT_W     = $clog2(PKT_FLITS);
    localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(PKT_FLITS - 1);
    localparam logic [IDX_W-1:0] LAST_SRC  = IDX_W'(NUM_SRCS - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [CNT_W-1:0] flit_cnt_q;

    logic [IDX_W-1:0] pick_idx;
    logic             any_req;
    logic             locked;
    logic             dst_xfer;

    ctrl_noc_rr_pick #(
        .NUM_SRCS (NUM_SRCS)
    ) u_pick (
        .req_i       (src_arb_val),
        .rr_ptr_i    (rr_ptr_q),
        .grant_idx_o (pick_idx),
        .any_req_o   (any_req)
    );

    assign locked   = (state_q == ST_LOCKED);
    assign dst_xfer = locked && src_arb_val[grant_q] && dst_arb_rdy;
    assign rr_ptr_d = (grant_q == LAST_SRC) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            flit_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q    <= pick_idx;
                        flit_cnt_q <= '0;
                        state_q    <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    // A stalled source or downstream simply holds everything.
                    if (dst_xfer) begin
                        if (flit_cnt_q == LAST_FLIT) begin
                            state_q  <= ST_IDLE;
                            rr_ptr_q <= rr_ptr_d;
                        end else begin
                            flit_cnt_q <= flit_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Passthrough datapath while locked; everything quiet in IDLE.
    always_comb begin
        arb_src_rdy  = '0;
        arb_dst_val  = 1'b0;
        arb_dst_data = '0;
        if (locked) begin
            arb_src_rdy[grant_q] = dst_arb_rdy;
            arb_dst_val          = src_arb_val[grant_q];
            arb_dst_data         = src_arb_data[grant_q];
        end
    end

    assign arb_busy      = locked;
    assign arb_grant_idx = grant_q;

endmodule

// File: tb/tb_ctrl_noc_pkt_rr_arb.sv
// tb/tb_ctrl_noc_pkt_rr_arb.sv - scoreboard bench for ctrl_noc_pkt_rr_arb
module tb_ctrl_noc_pkt_rr_arb;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int PF = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      src_arb_val;
    logic [N-1:0][W-1:0] src_arb_data;
    logic [N-1:0]      arb_src_rdy;
    logic              arb_dst_val;
    logic [W-1:0]      arb_dst_data;
    logic              dst_arb_rdy;
    logic [1:0]        arb_grant_idx;
    logic              arb_busy;

    ctrl_noc_pkt_rr_arb #(
        .NUM_SRCS (N),
        .EXTRA_W  (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_arb_val   (src_arb_val),
        .src_arb_data  (src_arb_data),
        .arb_src_rdy   (arb_src_rdy),
        .arb_dst_val   (arb_dst_val),
        .arb_dst_data  (arb_dst_data),
        .dst_arb_rdy   (dst_arb_rdy),
        .arb_grant_idx (arb_grant_idx),
        .arb_busy      (arb_busy)
    );

    always #5 clk = ~clk;

    logic [W-1:0] flit_q [N][$];
    logic [W-1:0] exp_q  [N][$];
    int           order_q[$];
    logic [N-1:0] en;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int pkt_seq   = 0;
    int pkt_pos   = 0;
    int cur_src   = 0;
    int last_x    = -1;
    int delivered = 0;
    bit chk_gap   = 1'b0;

    logic         s_dst_val, s_busy;
    logic [N-1:0] s_src_rdy;
    logic [1:0]   s_grant;
    logic [W-1:0] s_data;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_pkt(input int s);
        logic [W-1:0] d;
        for (int f = 0; f < PF; f++) begin
            d = {8'($urandom_range(0, 255)), 8'(s), 32'(pkt_seq), 16'(f)};
            flit_q[s].push_back(d);
            exp_q[s].push_back(d);
        end
        pkt_seq++;
    endtask

    task automatic drive_srcs();
        for (int s = 0; s < N; s++) begin
            src_arb_val[s]  = en[s] && (flit_q[s].size() != 0);
            src_arb_data[s] = (flit_q[s].size() != 0) ? flit_q[s][0] : '0;
        end
    endtask

    task automatic score(input logic [W-1:0] d);
        logic [W-1:0] e;
        if (pkt_pos == 0) begin
            if (order_q.size() == 0) begin
                check_eq("order_underflow", 64'(order_q.size()), 64'd1);
            end else begin
                cur_src = order_q.pop_front();
            end
        end
        if (exp_q[cur_src].size() == 0) begin
            check_eq("exp_underflow", 64'(exp_q[cur_src].size()), 64'd1);
        end else begin
            e = exp_q[cur_src].pop_front();
            check_eq("flit_data", d, e);
        end
        if (chk_gap && last_x >= 0)
            check_eq("flit_spacing", 64'(cyc - last_x), (pkt_pos == 0) ? 64'd2 : 64'd1);
        last_x    = cyc;
        delivered++;
        pkt_pos   = (pkt_pos == PF - 1) ? 0 : pkt_pos + 1;
    endtask

    // One clock: sample outputs at negedge, apply handshakes after the edge.
    task automatic cycle();
        logic [N-1:0] sx;
        logic         dx;
        @(negedge clk);
        s_dst_val = arb_dst_val;
        s_busy    = arb_busy;
        s_src_rdy = arb_src_rdy;
        s_grant   = arb_grant_idx;
        s_data    = arb_dst_data;
        sx        = src_arb_val & arb_src_rdy;
        dx        = arb_dst_val & dst_arb_rdy;
        @(posedge clk);
        #1;
        cyc++;
        for (int s = 0; s < N; s++)
            if (sx[s]) void'(flit_q[s].pop_front());
        if (dx) score(s_data);
        drive_srcs();
    endtask

    function automatic int pending();
        int n = 0;
        for (int s = 0; s < N; s++) n += flit_q[s].size();
        return n;
    endfunction

    task automatic drain(input string tag);
        int n = 0;
        int left = 0;
        while ((pending() != 0 || arb_busy) && n < 300) begin
            cycle();
            n++;
        end
        check_eq(tag, 64'(n < 300), 64'd1);
        for (int s = 0; s < N; s++) left += exp_q[s].size();
        left += order_q.size();
        check_eq("scoreboard_empty", 64'(left), 64'd0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_src_rdy"}, 64'(s_src_rdy), 64'd0);
        check_eq({tag, "_dst_val"}, 64'(s_dst_val), 64'd0);
        check_eq({tag, "_busy"},    64'(s_busy),    64'd0);
        check_eq({tag, "_grant"},   64'(s_grant),   64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [W-1:0] held;
        rst          = 1'b1;
        dst_arb_rdy  = 1'b1;
        en           = '1;
        src_arb_val  = '0;
        src_arb_data = '0;
        #1;
        cycle();
        cycle();
        check_quiet("reset");
        rst = 1'b0;
        cycle();
        check_quiet("post_reset");

        // Single source, then rr_ptr probe with sources 0 and 2.
        send_pkt(1); order_q.push_back(1); drive_srcs();
        cycle();
        check_eq("s1_idle_val", 64'(s_dst_val), 64'd0);
        cycle();
        check_eq("s1_lat_val", 64'(s_dst_val), 64'd1);
        check_eq("s1_grant", 64'(s_grant), 64'd1);
        cycle();
        check_eq("s1_flit_b_val", 64'(s_dst_val), 64'd1);
        cycle();
        check_eq("s1_flit_c_val", 64'(s_dst_val), 64'd1);
        cycle();
        check_eq("s1_back_idle", 64'(s_busy), 64'd0);
        send_pkt(0); send_pkt(2);
        order_q.push_back(2); order_q.push_back(0);
        drive_srcs();
        drain("s1_drain");

        // All four sources valid from reset: order 0,1,2,3,0 with one bubble.
        rst = 1'b1;
        send_pkt(0); send_pkt(1); send_pkt(2); send_pkt(3); send_pkt(0);
        order_q = '{0, 1, 2, 3, 0};
        drive_srcs();
        cycle();
        cycle();
        rst = 1'b0; chk_gap = 1'b1; last_x = -1;
        drain("s2_drain");
        chk_gap = 1'b0;

        // src2 locked, src0 arrives mid-packet and waits.
        send_pkt(2); order_q.push_back(2); drive_srcs();
        cycle();
        cycle();
        check_eq("s3_grant2", 64'(s_grant), 64'd2);
        send_pkt(0); order_q.push_back(0); drive_srcs();
        cycle();
        check_eq("s3_src0_rdy_b", 64'(s_src_rdy[0]), 64'd0);
        cycle();
        check_eq("s3_src0_rdy_c", 64'(s_src_rdy[0]), 64'd0);
        cycle();
        check_eq("s3_idle", 64'(s_busy), 64'd0);
        cycle();
        check_eq("s3_grant0", 64'(s_grant), 64'd0);
        drain("s3_drain");

        // Downstream ready pattern 1,0,0,1,1 on a src1 packet.
        send_pkt(1); order_q.push_back(1); drive_srcs();
        base = delivered;
        cycle();
        cycle();
        held = exp_q[1][0];
        dst_arb_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check_eq("s4_hold_val",  64'(s_dst_val), 64'd1);
            check_eq("s4_hold_data", s_data, held);
            check_eq("s4_hold_rdy",  64'(s_src_rdy), 64'd0);
        end
        dst_arb_rdy = 1'b1;
        cycle();
        cycle();
        cycle();
        check_eq("s4_idle", 64'(s_busy), 64'd0);
        check_eq("s4_count", 64'(delivered - base), 64'd3);

        // Reset mid-packet of src3, then src0 and src3 compete.
        send_pkt(3); order_q.push_back(3); drive_srcs();
        cycle();
        cycle();
        check_eq("s5_grant3", 64'(s_grant), 64'd3);
        cycle();
        rst = 1'b1; dst_arb_rdy = 1'b0;
        cycle();
        rst = 1'b0; dst_arb_rdy = 1'b1;
        flit_q[3].delete(); exp_q[3].delete(); pkt_pos = 0;
        drive_srcs();
        cycle();
        check_quiet("s5_after_rst");
        send_pkt(0); send_pkt(3);
        order_q.push_back(0); order_q.push_back(3);
        drive_srcs();
        cycle();
        cycle();
        check_eq("s5_grant0", 64'(s_grant), 64'd0);
        drain("s5_drain");

        // Granted source drops val mid-packet; src2 valid but ignored.
        send_pkt(1); order_q.push_back(1); drive_srcs();
        cycle();
        cycle();
        en[1] = 1'b0;
        send_pkt(2); order_q.push_back(2);
        drive_srcs();
        for (int i = 0; i < 2; i++) begin
            cycle();
            check_eq("s6_stall_val",   64'(s_dst_val), 64'd0);
            check_eq("s6_stall_busy",  64'(s_busy),    64'd1);
            check_eq("s6_stall_grant", 64'(s_grant),   64'd1);
            check_eq("s6_stall_rdy",   64'(s_src_rdy & 4'b1101), 64'd0);
        end
        en[1] = 1'b1;
        drive_srcs();
        drain("s6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
